// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: ID->EX pipeline register bus (ID/WB inputs, EX-side outputs, counters)
interface id_ex_pipe_reg_if #(parameter int CNT_W = 16);
  logic             Stall, Flush, Hold_ex;
  logic             MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id, ALUSrcA_id;
  logic [3:0]       ALUCode_id;
  logic [1:0]       ALUSrcB_id;
  logic [31:0]      PC_id, Imm_id, rs1Data_id, rs2Data_id;
  logic [4:0]       rs1Addr_id, rs2Addr_id, rdAddr_id;
  logic             RegWrite_wb;
  logic [4:0]       rdAddr_wb;
  logic [31:0]      RegWriteData_wb;
  logic             MemtoReg_ex, RegWrite_ex, MemWrite_ex, MemRead_ex, ALUSrcA_ex;
  logic [3:0]       ALUCode_ex;
  logic [1:0]       ALUSrcB_ex;
  logic [31:0]      PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex;
  logic [4:0]       rs1Addr_ex, rs2Addr_ex, rdAddr_ex;
  logic             Valid_ex;
  logic [CNT_W-1:0] BubbleCnt, HoldCnt;
  modport master (
    output Stall, Flush, Hold_ex, MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id, ALUSrcA_id,
           ALUCode_id, ALUSrcB_id, PC_id, Imm_id, rs1Data_id, rs2Data_id, rs1Addr_id, rs2Addr_id,
           rdAddr_id, RegWrite_wb, rdAddr_wb, RegWriteData_wb,
    input  MemtoReg_ex, RegWrite_ex, MemWrite_ex, MemRead_ex, ALUSrcA_ex, ALUCode_ex, ALUSrcB_ex,
           PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex, rs1Addr_ex, rs2Addr_ex, rdAddr_ex, Valid_ex,
           BubbleCnt, HoldCnt
  );
  modport slave (
    input  Stall, Flush, Hold_ex, MemtoReg_id, RegWrite_id, MemWrite_id, MemRead_id, ALUSrcA_id,
           ALUCode_id, ALUSrcB_id, PC_id, Imm_id, rs1Data_id, rs2Data_id, rs1Addr_id, rs2Addr_id,
           rdAddr_id, RegWrite_wb, rdAddr_wb, RegWriteData_wb,
    output MemtoReg_ex, RegWrite_ex, MemWrite_ex, MemRead_ex, ALUSrcA_ex, ALUCode_ex, ALUSrcB_ex,
           PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex, rs1Addr_ex, rs2Addr_ex, rdAddr_ex, Valid_ex,
           BubbleCnt, HoldCnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with bubble/hold, WB bypass and perf counters
module id_ex_pipe_reg #(
  parameter bit BYPASS_WB = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_pipe_reg_if.slave   bus
);
  logic             r_memtoreg, r_regwrite, r_memwrite, r_memread, r_alusrca, r_valid;
  logic [3:0]       r_alucode;
  logic [1:0]       r_alusrcb;
  logic [31:0]      r_pc, r_imm, r_rs1data, r_rs2data;
  logic [4:0]       r_rs1addr, r_rs2addr, r_rdaddr;
  logic [CNT_W-1:0] r_bubcnt, r_holdcnt;
  logic             w_bubble, w_byp1, w_byp2;
  logic [31:0]      w_rs1data, w_rs2data;
  assign w_bubble  = bus.Stall | bus.Flush;
  assign w_byp1    = BYPASS_WB && bus.RegWrite_wb && (bus.rdAddr_wb != 5'd0) && (bus.rdAddr_wb == bus.rs1Addr_id);
  assign w_byp2    = BYPASS_WB && bus.RegWrite_wb && (bus.rdAddr_wb != 5'd0) && (bus.rdAddr_wb == bus.rs2Addr_id);
  assign w_rs1data = w_byp1 ? bus.RegWriteData_wb : bus.rs1Data_id;
  assign w_rs2data = w_byp2 ? bus.RegWriteData_wb : bus.rs2Data_id;
  // Stage register: freeze on hold, kill side-effecting controls on a bubble, else load ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_memtoreg, r_regwrite, r_memwrite, r_memread, r_alusrca, r_valid} <= '0;
      r_alucode <= '0;
      r_alusrcb <= '0;
      {r_pc, r_imm, r_rs1data, r_rs2data} <= '0;
      {r_rs1addr, r_rs2addr, r_rdaddr} <= '0;
    end else if (!bus.Hold_ex) begin
      r_valid    <= ~w_bubble;
      r_memtoreg <= ~w_bubble & bus.MemtoReg_id;
      r_regwrite <= ~w_bubble & bus.RegWrite_id;
      r_memwrite <= ~w_bubble & bus.MemWrite_id;
      r_memread  <= ~w_bubble & bus.MemRead_id;
      r_rdaddr   <= w_bubble ? 5'd0 : bus.rdAddr_id;
      r_alucode  <= w_bubble ? 4'd0 : bus.ALUCode_id;
      r_alusrca  <= bus.ALUSrcA_id;
      r_alusrcb  <= bus.ALUSrcB_id;
      r_pc       <= bus.PC_id;
      r_imm      <= bus.Imm_id;
      r_rs1data  <= w_rs1data;
      r_rs2data  <= w_rs2data;
      r_rs1addr  <= bus.rs1Addr_id;
      r_rs2addr  <= bus.rs2Addr_id;
    end
  end
  // Saturating performance counters; a combined Stall+Flush counts as one bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubcnt  <= '0;
      r_holdcnt <= '0;
    end else begin
      if (bus.Hold_ex && r_holdcnt != '1) r_holdcnt <= r_holdcnt + 1'b1;
      if (!bus.Hold_ex && w_bubble && r_bubcnt != '1) r_bubcnt <= r_bubcnt + 1'b1;
    end
  end
  assign bus.MemtoReg_ex = r_memtoreg;
  assign bus.RegWrite_ex = r_regwrite;
  assign bus.MemWrite_ex = r_memwrite;
  assign bus.MemRead_ex  = r_memread;
  assign bus.ALUSrcA_ex  = r_alusrca;
  assign bus.ALUCode_ex  = r_alucode;
  assign bus.ALUSrcB_ex  = r_alusrcb;
  assign bus.PC_ex       = r_pc;
  assign bus.Imm_ex      = r_imm;
  assign bus.rs1Data_ex  = r_rs1data;
  assign bus.rs2Data_ex  = r_rs2data;
  assign bus.rs1Addr_ex  = r_rs1addr;
  assign bus.rs2Addr_ex  = r_rs2addr;
  assign bus.rdAddr_ex   = r_rdaddr;
  assign bus.Valid_ex    = r_valid;
  assign bus.BubbleCnt   = r_bubcnt;
  assign bus.HoldCnt     = r_holdcnt;
endmodule
